// File: rtl/aes_encipher_block_gen2.sv
// aes_encipher_block_gen2: iterative AES encipher datapath for 128/192/256-bit key modes,
// substituting SBOX_LANES state words per cycle through an external S-box.
module aes_encipher_block_gen2 #(
  parameter int SBOX_LANES = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    next,
  input  logic [1:0]              keylen,
  output logic [3:0]              round,
  input  logic [127:0]            round_key,
  output logic [32*SBOX_LANES-1:0] sboxw,
  input  logic [32*SBOX_LANES-1:0] new_sboxw,
  input  logic [127:0]            block,
  output logic [127:0]            new_block,
  output logic                    ready,
  output logic                    done
);
  localparam int S = 4 / SBOX_LANES;
  localparam int W = 32 * SBOX_LANES;

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_e;

  state_e       state_q;
  logic [127:0] st_q, st_sb_d;
  logic [3:0]   round_q, nr_q;
  logic [1:0]   cnt_q;
  logic         ready_q, done_q;
  logic [6:0]   lo;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3, xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0,
            xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1, xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
    return o;
  endfunction

  // Cycle c of a round substitutes the W-bit slice starting at word c*SBOX_LANES.
  always_comb begin
    lo = 7'(128 - W * (int'(cnt_q) + 1));
    st_sb_d = st_q;
    st_sb_d[lo +: W] = new_sboxw;
  end

  assign sboxw     = (state_q == SBOX) ? st_q[lo +: W] : '0;
  assign round     = round_q;
  assign new_block = st_q;
  assign ready     = ready_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      round_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      nr_q    <= 4'd10;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (next) begin
          nr_q    <= keylen == 2'b01 ? 4'd12 : keylen == 2'b10 ? 4'd14 : 4'd10;
          round_q <= '0;
          ready_q <= 1'b0;
          state_q <= INIT;
        end
        INIT: begin
          st_q    <= block ^ round_key;
          round_q <= 4'd1;
          cnt_q   <= '0;
          state_q <= SBOX;
        end
        SBOX: begin
          st_q    <= st_sb_d;
          cnt_q   <= cnt_q + 2'd1;
          state_q <= cnt_q == 2'(S - 1) ? MAIN : SBOX;
        end
        MAIN: begin
          cnt_q <= '0;
          if (round_q < nr_q) begin
            st_q    <= mix_columns(shift_rows(st_q)) ^ round_key;
            round_q <= round_q + 4'd1;
            state_q <= SBOX;
          end else begin
            st_q    <= shift_rows(st_q) ^ round_key;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encipher_block_gen2.sv
// tb_aes_encipher_block_gen2: runs FIPS-197 vectors through 1-, 2- and 4-lane instances
// with a bench-side key memory and S-box.
module tb_aes_encipher_block_gen2;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   nx;
  logic [1:0]   keylen;
  logic [127:0] block;
  logic [7:0]   sb [256];
  logic [127:0] rk [16];
  logic [3:0]   rnd0, rnd1, rnd2;
  logic [127:0] nb0, nb1, nb2;
  logic [31:0]  sw0, nsw0;
  logic [63:0]  sw1, nsw1;
  logic [127:0] sw2, nsw2;
  logic [2:0]   rdy, dn;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) assign nsw0[8*i +: 8] = sb[sw0[8*i +: 8]];
  for (genvar i = 0; i < 8; i++) assign nsw1[8*i +: 8] = sb[sw1[8*i +: 8]];
  for (genvar i = 0; i < 16; i++) assign nsw2[8*i +: 8] = sb[sw2[8*i +: 8]];

  aes_encipher_block_gen2 #(.SBOX_LANES(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .next(nx[0]), .keylen(keylen), .round(rnd0),
    .round_key(rk[rnd0]), .sboxw(sw0), .new_sboxw(nsw0), .block(block),
    .new_block(nb0), .ready(rdy[0]), .done(dn[0]));
  aes_encipher_block_gen2 #(.SBOX_LANES(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .next(nx[1]), .keylen(keylen), .round(rnd1),
    .round_key(rk[rnd1]), .sboxw(sw1), .new_sboxw(nsw1), .block(block),
    .new_block(nb1), .ready(rdy[1]), .done(dn[1]));
  aes_encipher_block_gen2 #(.SBOX_LANES(4)) u_l4 (
    .clk(clk), .reset_n(reset_n), .next(nx[2]), .keylen(keylen), .round(rnd2),
    .round_key(rk[rnd2]), .sboxw(sw2), .new_sboxw(nsw2), .block(block),
    .new_block(nb2), .ready(rdy[2]), .done(dn[2]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Key bytes are 00,01,02,... for the nk*4 key bytes of each test vector.
  task automatic expand(input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < nk + 7; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic int s_of(input int i);
    return i == 0 ? 4 : i == 1 ? 2 : 1;
  endfunction
  function automatic logic [3:0] rnd_of(input int i);
    return i == 0 ? rnd0 : i == 1 ? rnd1 : rnd2;
  endfunction
  function automatic logic [127:0] nb_of(input int i);
    return i == 0 ? nb0 : i == 1 ? nb1 : nb2;
  endfunction
  function automatic logic sb_on(input int i);
    return i == 0 ? |sw0 : i == 1 ? |sw1 : |sw2;
  endfunction

  task automatic run(input logic [1:0] kl, input int nk, input logic [127:0] exp,
                     input bit poke, input int reps, input string tag);
    int nr, rel, last;
    int lat [3], st [3], ops [3], nd [3], bad [3];
    logic [2:0] nxn;
    logic sbx;
    nr = nk + 6;
    expand(nk);
    keylen = kl;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 1 + nr * (s_of(i) + 1);
      st[i] = 0; ops[i] = 0; nd[i] = 0; bad[i] = 0;
    end
    @(negedge clk); nx = 3'b111;
    @(posedge clk); #1; nx = 3'b000;
    last = 0;
    for (int k = 1; k < 600; k++) begin
      @(posedge clk); #1;
      nxn = '0;
      if (poke && (k == 5 || k == 20)) nxn = 3'b111;
      if (poke && k == 10) keylen = ~kl;
      for (int i = 0; i < 3; i++) begin
        rel = k - st[i];
        nd[i] += int'(dn[i]);
        if (rnd_of(i) > 4'(nr)) bad[i]++;
        sbx = ops[i] < reps && rel >= 1 && rel < lat[i] && (rel - 1) % (s_of(i) + 1) < s_of(i);
        if (sb_on(i) != sbx) bad[i]++;
        if (dn[i] && ops[i] < reps) begin
          check($sformatf("%s_l%0d_lat", tag, i), rel, lat[i]);
          check($sformatf("%s_l%0d_ct", tag, i), nb_of(i), exp);
          check($sformatf("%s_l%0d_rdy", tag, i), rdy[i], 1);
          ops[i]++;
          if (ops[i] < reps) begin
            st[i] = k + 1;
            nxn[i] = 1'b1;
          end
        end
      end
      nx = nxn;
      if (last == 0 && ops[0] == reps && ops[1] == reps && ops[2] == reps) last = k;
      if (last != 0 && k >= last + 3) break;
    end
    nx = '0;
    keylen = kl;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_l%0d_done_cnt", tag, i), nd[i], reps);
      check($sformatf("%s_l%0d_sbox_round", tag, i), bad[i], 0);
      check($sformatf("%s_l%0d_hold", tag, i), nb_of(i), exp);
    end
  endtask

  task automatic reset_mid_run();
    expand(4);
    keylen = 2'b00;
    @(negedge clk); nx = 3'b111;
    @(posedge clk); #1; nx = 3'b000;
    for (int k = 0; k < 300 && rnd0 != 4'd6; k++) begin
      @(posedge clk); #1;
    end
    check("rst_reach_round6", rnd0, 6);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_l%0d_ready", i), rdy[i], 1);
      check($sformatf("rst_l%0d_block", i), nb_of(i), 0);
      check($sformatf("rst_l%0d_round", i), rnd_of(i), 0);
      check($sformatf("rst_l%0d_done", i), dn[i], 0);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    nx = '0;
    keylen = 2'b00;
    block = PT;
    build_sbox();
    expand(4);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("init_l%0d_ready", i), rdy[i], 1);
      check($sformatf("init_l%0d_done", i), dn[i], 0);
      check($sformatf("init_l%0d_round", i), rnd_of(i), 0);
      check($sformatf("init_l%0d_block", i), nb_of(i), 0);
      check($sformatf("init_l%0d_sboxw", i), sb_on(i), 0);
    end
    @(negedge clk); reset_n = 1'b1;
    run(2'b00, 4, C128, 1'b0, 1, "k128");
    run(2'b01, 6, C192, 1'b0, 1, "k192");
    run(2'b10, 8, C256, 1'b0, 1, "k256");
    run(2'b00, 4, C128, 1'b1, 1, "busy_poke");
    reset_mid_run();
    run(2'b00, 4, C128, 1'b0, 1, "post_rst");
    run(2'b11, 4, C128, 1'b0, 2, "k11_b2b");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
